// File: rtl/pe_array_ctrl_pkg.sv
// Shared widths, FSM state encoding, error causes and the SRAM address helper
// for the pe_array sequencer.
package pe_array_ctrl_pkg;

    localparam int K_MAX      = 16;
    localparam int K_W        = $clog2(K_MAX);
    localparam int TILE_W     = 8;
    localparam int ADDR_W     = 10;
    localparam int IN_W       = 256;
    localparam int WT_W       = 32;
    localparam int RV_TIMEOUT = 64;
    localparam int TMR_W      = $clog2(RV_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FEED    = 3'd1,
        S_LAST    = 3'd2,
        S_ROUND   = 3'd3,
        S_WAIT_RV = 3'd4,
        S_OUT     = 3'd5,
        S_DONE    = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_TIMEOUT   = 2'd1,
        ERR_ROUND_NUM = 2'd2
    } err_cause_e;

    // Row address of one beat; wraps modulo 2^ADDR_W by construction.
    function automatic logic [ADDR_W-1:0] sram_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [ADDR_W-1:0] tile_off,
                                                    input logic [K_W-1:0]    step);
        return base + tile_off + ADDR_W'(step);
    endfunction

endpackage

// File: rtl/pe_array_ctrl_if.sv
// SRAM read ports and tile-result handshake between the sequencer (master)
// and its SRAM / writeback neighbours (slave).
interface pe_array_ctrl_if;
    import pe_array_ctrl_pkg::*;

    logic              in_rd_en;
    logic [ADDR_W-1:0] in_rd_addr;
    logic [IN_W-1:0]   in_rd_data;
    logic              wt_rd_en;
    logic [ADDR_W-1:0] wt_rd_addr;
    logic [WT_W-1:0]   wt_rd_data;
    logic              res_valid;
    logic              res_ready;
    logic [TILE_W-1:0] res_tile;

    modport master (
        output in_rd_en, in_rd_addr, wt_rd_en, wt_rd_addr, res_valid, res_tile,
        input  in_rd_data, wt_rd_data, res_ready
    );

    modport slave (
        input  in_rd_en, in_rd_addr, wt_rd_en, wt_rd_addr, res_valid, res_tile,
        output in_rd_data, wt_rd_data, res_ready
    );

endinterface

// File: rtl/pe_array_ctrl_addr_gen.sv
// Step/tile counters and SRAM address generation. The beat pipeline delays the
// step index by one cycle so add_number/keep line up with returning SRAM data.
module pe_array_ctrl_addr_gen
    import pe_array_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              issue,
    input  logic              tile_adv,
    input  logic [K_W-1:0]    cfg_k,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] wt_base,
    output logic [ADDR_W-1:0] in_addr,
    output logic [ADDR_W-1:0] wt_addr,
    output logic              step_last,
    output logic [TILE_W-1:0] tile,
    output logic              beat_vld,
    output logic [K_W-1:0]    beat_step
);

    logic [K_W-1:0]    step_q, step_d;
    logic [TILE_W-1:0] tile_q, tile_d;
    logic [ADDR_W-1:0] tile_off_q, tile_off_d;
    logic              beat_vld_q, beat_vld_d;
    logic [K_W-1:0]    beat_step_q, beat_step_d;

    assign step_last = (step_q == cfg_k);

    // Counter updates; tile_off tracks tile*(cfg_k+1) incrementally, no multiplier.
    always_comb begin
        step_d      = step_q;
        tile_d      = tile_q;
        tile_off_d  = tile_off_q;
        beat_vld_d  = issue;
        beat_step_d = issue ? step_q : beat_step_q;
        if (clr) begin
            step_d     = '0;
            tile_d     = '0;
            tile_off_d = '0;
        end else if (tile_adv) begin
            step_d     = '0;
            tile_d     = tile_q + TILE_W'(1);
            tile_off_d = tile_off_q + ADDR_W'(cfg_k) + ADDR_W'(1);
        end else if (issue) begin
            step_d = step_last ? '0 : step_q + K_W'(1);
        end
    end

    // Counter and beat-pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q      <= '0;
            tile_q      <= '0;
            tile_off_q  <= '0;
            beat_vld_q  <= 1'b0;
            beat_step_q <= '0;
        end else begin
            step_q      <= step_d;
            tile_q      <= tile_d;
            tile_off_q  <= tile_off_d;
            beat_vld_q  <= beat_vld_d;
            beat_step_q <= beat_step_d;
        end
    end

    // Addresses are forced to zero when no read is being issued.
    always_comb begin
        in_addr = issue ? sram_addr(in_base, tile_off_q, step_q) : '0;
        wt_addr = issue ? sram_addr(wt_base, tile_off_q, step_q) : '0;
    end

    assign tile      = tile_q;
    assign beat_vld  = beat_vld_q;
    assign beat_step = beat_step_q;

endmodule

// File: rtl/pe_array_ctrl.sv
// Tile sequencer for pe_array: feeds K rows/weight pairs per tile, triggers the
// rounder, waits for its result (with timeout) and hands the tile to writeback.
//
//  state   | meaning
//  IDLE    | waiting for start; array frozen (keep=1)
//  FEED    | one SRAM read per cycle, steps 0..cfg_k
//  LAST    | final beat returns from SRAM, no read
//  ROUND   | 1-cycle rounder trigger
//  WAIT_RV | waiting for rounder_valid, bounded by RV_TIMEOUT
//  OUT     | tile result presented until res_ready
//  DONE    | 1-cycle done pulse
module pe_array_ctrl
    import pe_array_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [K_W-1:0]    cfg_k,
    input  logic [TILE_W-1:0] cfg_tiles,
    input  logic [ADDR_W-1:0] cfg_in_base,
    input  logic [ADDR_W-1:0] cfg_wt_base,
    pe_array_ctrl_if.master   bus,
    output logic [IN_W-1:0]   data_input_matrix,
    output logic [WT_W-1:0]   data_weight_matrix,
    output logic              keep,
    output logic [K_W-1:0]    add_number,
    output logic              rounder_en,
    input  logic              rounder_valid,
    input  logic [K_W-1:0]    round_number,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e            state_q, state_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [TILE_W-1:0] tiles_q, tiles_d;
    logic [ADDR_W-1:0] in_base_q, in_base_d;
    logic [ADDR_W-1:0] wt_base_q, wt_base_d;
    logic              err_q, err_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    err_cause_e        cause;

    logic              accept, issue, hs, last_tile, tile_adv, rv_hit, tmo;
    logic [ADDR_W-1:0] in_addr, wt_addr;
    logic              step_last, beat_vld;
    logic [TILE_W-1:0] tile;
    logic [K_W-1:0]    beat_step;

    assign accept    = (state_q == S_IDLE) && start;
    assign issue     = (state_q == S_FEED);
    assign hs        = (state_q == S_OUT) && bus.res_ready;
    assign last_tile = (tile == tiles_q);
    assign tile_adv  = hs && !last_tile;
    assign rv_hit    = (state_q == S_WAIT_RV) && rounder_valid;
    assign tmo       = (state_q == S_WAIT_RV) && !rounder_valid && (tmr_q == '0);

    pe_array_ctrl_addr_gen u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (accept),
        .issue     (issue),
        .tile_adv  (tile_adv),
        .cfg_k     (k_q),
        .in_base   (in_base_q),
        .wt_base   (wt_base_q),
        .in_addr   (in_addr),
        .wt_addr   (wt_addr),
        .step_last (step_last),
        .tile      (tile),
        .beat_vld  (beat_vld),
        .beat_step (beat_step)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; rounder_valid outside WAIT_RV has no effect.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (start) state_d = S_FEED;
            S_FEED:    if (step_last) state_d = S_LAST;
            S_LAST:    state_d = S_ROUND;
            S_ROUND:   state_d = S_WAIT_RV;
            S_WAIT_RV: if (rounder_valid || tmr_q == '0) state_d = S_OUT;
            S_OUT:     if (bus.res_ready) state_d = last_tile ? S_DONE : S_FEED;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Job config capture, sticky error and rounder timeout down-counter.
    always_comb begin
        cause = ERR_NONE;
        if (rv_hit && round_number != k_q) cause = ERR_ROUND_NUM;
        else if (tmo)                      cause = ERR_TIMEOUT;

        k_d       = accept ? cfg_k       : k_q;
        tiles_d   = accept ? cfg_tiles   : tiles_q;
        in_base_d = accept ? cfg_in_base : in_base_q;
        wt_base_d = accept ? cfg_wt_base : wt_base_q;
        err_d     = accept ? 1'b0 : (err_q || cause != ERR_NONE);

        tmr_d = tmr_q;
        if (state_q == S_ROUND)                          tmr_d = TMR_W'(RV_TIMEOUT - 1);
        else if (state_q == S_WAIT_RV && tmr_q != '0)    tmr_d = tmr_q - TMR_W'(1);
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q       <= '0;
            tiles_q   <= '0;
            in_base_q <= '0;
            wt_base_q <= '0;
            err_q     <= 1'b0;
            tmr_q     <= '0;
        end else begin
            k_q       <= k_d;
            tiles_q   <= tiles_d;
            in_base_q <= in_base_d;
            wt_base_q <= wt_base_d;
            err_q     <= err_d;
            tmr_q     <= tmr_d;
        end
    end

    // Output decode; beats pass SRAM data straight to the array in the cycle it returns.
    always_comb begin
        data_input_matrix  = beat_vld ? bus.in_rd_data : '0;
        data_weight_matrix = beat_vld ? bus.wt_rd_data : '0;
        keep               = beat_vld ? (beat_step != '0) : 1'b1;
        add_number         = '0;
        if (beat_vld)
            add_number = beat_step;
        else if (state_q == S_ROUND || state_q == S_WAIT_RV || state_q == S_OUT)
            add_number = k_q;
        rounder_en = (state_q == S_ROUND);
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_DONE);
        err        = err_q;
    end

    assign bus.in_rd_en   = issue;
    assign bus.wt_rd_en   = issue;
    assign bus.in_rd_addr = in_addr;
    assign bus.wt_rd_addr = wt_addr;
    assign bus.res_valid  = (state_q == S_OUT);
    assign bus.res_tile   = (state_q == S_OUT) ? tile : '0;

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Scoreboard bench for pe_array_ctrl: job tasks push expected reads, beats and
// result tiles; a negedge monitor pops and compares as the DUT presents them.
module tb_pe_array_ctrl;
    import pe_array_ctrl_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [K_W-1:0]    cfg_k = '0;
    logic [TILE_W-1:0] cfg_tiles = '0;
    logic [ADDR_W-1:0] cfg_in_base = '0;
    logic [ADDR_W-1:0] cfg_wt_base = '0;
    logic [IN_W-1:0]   data_input_matrix;
    logic [WT_W-1:0]   data_weight_matrix;
    logic              keep;
    logic [K_W-1:0]    add_number;
    logic              rounder_en;
    logic              rounder_valid = 1'b0;
    logic [K_W-1:0]    round_number = '0;
    logic              busy, done, err;

    pe_array_ctrl_if bus();

    pe_array_ctrl dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .cfg_k              (cfg_k),
        .cfg_tiles          (cfg_tiles),
        .cfg_in_base        (cfg_in_base),
        .cfg_wt_base        (cfg_wt_base),
        .bus                (bus),
        .data_input_matrix  (data_input_matrix),
        .data_weight_matrix (data_weight_matrix),
        .keep               (keep),
        .add_number         (add_number),
        .rounder_en         (rounder_en),
        .rounder_valid      (rounder_valid),
        .round_number       (round_number),
        .busy               (busy),
        .done               (done),
        .err                (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] in_a;
        logic [ADDR_W-1:0] wt_a;
        logic [K_W-1:0]    step;
    } rd_t;

    rd_t               addr_q[$];
    rd_t               beat_q[$];
    logic [TILE_W-1:0] tile_q[$];

    int   n_chk = 0;
    int   n_pass = 0;
    int   done_cnt = 0;
    int   rnd_cnt = 0;
    logic beat_pend = 1'b0;
    logic rv_enable = 1'b1;
    int   rv_delay = 0;
    logic [K_W-1:0] rv_num = '0;

    function automatic logic [IN_W-1:0] in_word(input logic [ADDR_W-1:0] a);
        return {16{6'h15, a}};
    endfunction

    function automatic logic [WT_W-1:0] wt_word(input logic [ADDR_W-1:0] a);
        return {6'h2A, a, ~{6'h00, a}};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // SRAM model: one-cycle read latency
    always @(posedge clk) begin
        if (bus.in_rd_en) bus.in_rd_data <= in_word(bus.in_rd_addr);
        if (bus.wt_rd_en) bus.wt_rd_data <= wt_word(bus.wt_rd_addr);
    end

    // Monitor
    always begin
        rd_t e;
        @(negedge clk);
        #1;
        if (!rst_n) begin
            beat_pend = 1'b0;
        end else begin
            if (beat_pend) begin
                if (beat_q.size() == 0) chk("beat_unexpected", 256'(1), 256'(0));
                else begin
                    e = beat_q.pop_front();
                    chk("beat_in_data", 256'(data_input_matrix), 256'(in_word(e.in_a)));
                    chk("beat_wt_data", 256'(data_weight_matrix), 256'(wt_word(e.wt_a)));
                    chk("beat_add_number", 256'(add_number), 256'(e.step));
                    chk("beat_keep", 256'(keep), 256'(e.step != '0));
                end
            end
            if (bus.in_rd_en) begin
                if (addr_q.size() == 0) chk("rd_unexpected", 256'(1), 256'(0));
                else begin
                    e = addr_q.pop_front();
                    chk("in_rd_addr", 256'(bus.in_rd_addr), 256'(e.in_a));
                    chk("wt_rd_addr", 256'(bus.wt_rd_addr), 256'(e.wt_a));
                    chk("wt_rd_en", 256'(bus.wt_rd_en), 256'(1));
                end
            end
            if (bus.res_valid && bus.res_ready) begin
                if (tile_q.size() == 0) chk("res_unexpected", 256'(1), 256'(0));
                else chk("res_tile", 256'(bus.res_tile), 256'(tile_q.pop_front()));
            end
            if (rounder_en) rnd_cnt++;
            if (done) done_cnt++;
            beat_pend = bus.in_rd_en;
        end
    end

    // Rounder model: answers rv_delay cycles into WAIT_RV
    initial forever begin
        @(negedge clk);
        if (rst_n && rounder_en && rv_enable) begin
            repeat (rv_delay + 1) @(negedge clk);
            rounder_valid = 1'b1;
            round_number  = rv_num;
            @(negedge clk);
            rounder_valid = 1'b0;
        end
    end

    task automatic start_job(input int k, input int tiles, input int inb, input int wtb);
        rd_t e;
        for (int t = 0; t <= tiles; t++) begin
            for (int s = 0; s <= k; s++) begin
                e.in_a = ADDR_W'((inb + t * (k + 1) + s) % 1024);
                e.wt_a = ADDR_W'((wtb + t * (k + 1) + s) % 1024);
                e.step = K_W'(s);
                addr_q.push_back(e);
                beat_q.push_back(e);
            end
            tile_q.push_back(TILE_W'(t));
        end
        @(negedge clk);
        cfg_k       = K_W'(k);
        cfg_tiles   = TILE_W'(tiles);
        cfg_in_base = ADDR_W'(inb);
        cfg_wt_base = ADDR_W'(wtb);
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        cfg_k       = ~cfg_k;
        cfg_tiles   = ~cfg_tiles;
        cfg_in_base = ~cfg_in_base;
        cfg_wt_base = ~cfg_wt_base;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 256'(done), 256'(1));
        @(negedge clk);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_in_rd_en"}, 256'(bus.in_rd_en), 256'(0));
        chk({tag, "_in_rd_addr"}, 256'(bus.in_rd_addr), 256'(0));
        chk({tag, "_wt_rd_addr"}, 256'(bus.wt_rd_addr), 256'(0));
        chk({tag, "_data_in"}, 256'(data_input_matrix), 256'(0));
        chk({tag, "_data_wt"}, 256'(data_weight_matrix), 256'(0));
        chk({tag, "_add_number"}, 256'(add_number), 256'(0));
        chk({tag, "_keep"}, 256'(keep), 256'(1));
        chk({tag, "_rounder_en"}, 256'(rounder_en), 256'(0));
        chk({tag, "_res_valid"}, 256'(bus.res_valid), 256'(0));
        chk({tag, "_busy_done_err"}, 256'({busy, done, err}), 256'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, r0, n, c2;
        logic err_at_64;
        bus.res_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 1) K=4, one tile
        rv_delay = 2; rv_num = 4'd3;
        d0 = done_cnt; r0 = rnd_cnt;
        start_job(3, 0, 0, 0);
        chk("t1_busy", 256'(busy), 256'(1));
        wait_done("t1_done", 200);
        chk("t1_done_count", 256'(done_cnt - d0), 256'(1));
        chk("t1_rounder_count", 256'(rnd_cnt - r0), 256'(1));
        chk("t1_err", 256'(err), 256'(0));
        chk("t1_busy_after", 256'(busy), 256'(0));

        // 2) K=16, three tiles
        rv_delay = 0; rv_num = 4'd15;
        d0 = done_cnt;
        start_job(15, 2, 5, 'h100);
        wait_done("t2_done", 400);
        chk("t2_done_count", 256'(done_cnt - d0), 256'(1));
        chk("t2_tiles_left", 256'(tile_q.size()), 256'(0));
        chk("t2_err", 256'(err), 256'(0));

        // 3) writeback stall in OUT
        rv_num = 4'd1;
        bus.res_ready = 1'b0;
        start_job(1, 1, 20, 30);
        n = 0;
        while (!bus.res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t3_res_valid_seen", 256'(bus.res_valid), 256'(1));
        for (int i = 0; i < 10; i++) begin
            chk("t3_stall_res_valid", 256'(bus.res_valid), 256'(1));
            chk("t3_stall_keep", 256'(keep), 256'(1));
            chk("t3_stall_no_read", 256'(bus.in_rd_en), 256'(0));
            chk("t3_stall_res_tile", 256'(bus.res_tile), 256'(0));
            @(negedge clk);
        end
        bus.res_ready = 1'b1;
        wait_done("t3_done", 200);
        chk("t3_err", 256'(err), 256'(0));

        // 4) K=1 latency, then rounder timeout
        rv_enable = 1'b0;
        start_job(0, 0, 7, 8);
        n = 1;
        while (!rounder_en && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("t4_start_to_rounder_en", 256'(n), 256'(3));
        c2 = 0;
        err_at_64 = 1'b1;
        while (!bus.res_valid && c2 < 200) begin
            @(negedge clk);
            c2++;
            if (c2 == 64) err_at_64 = err;
        end
        chk("t4_rounder_en_to_out", 256'(c2), 256'(65));
        chk("t4_err_before_timeout", 256'(err_at_64), 256'(0));
        chk("t4_err_at_out", 256'(err), 256'(1));
        wait_done("t4_done", 50);
        chk("t4_err_sticky", 256'(err), 256'(1));
        rv_enable = 1'b1;

        // 5) wrong round_number; start while busy ignored; start clears err
        rv_num = 4'd2;
        d0 = done_cnt; r0 = rnd_cnt;
        start_job(3, 1, 100, 200);
        chk("t5_err_cleared", 256'(err), 256'(0));
        @(negedge clk);
        cfg_k = 4'd0; cfg_tiles = '0; cfg_in_base = 'h50; cfg_wt_base = 'h50;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t5_done", 200);
        chk("t5_err", 256'(err), 256'(1));
        chk("t5_done_count", 256'(done_cnt - d0), 256'(1));
        chk("t5_rounder_count", 256'(rnd_cnt - r0), 256'(2));

        // 6) address wrap, then reset mid-FEED
        rv_num = 4'd3;
        start_job(3, 0, 'h3FE, 'h3FD);
        wait_done("t6_done", 200);
        chk("t6_err", 256'(err), 256'(0));
        d0 = done_cnt;
        start_job(3, 5, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("t6_feeding", 256'(bus.in_rd_en), 256'(1));
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("t6_rst_async");
        addr_q.delete();
        beat_q.delete();
        tile_q.delete();
        @(negedge clk);
        chk_idle_outputs("t6_rst_edge");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_no_done_after_rst", 256'(done_cnt - d0), 256'(0));
        chk("t6_idle_after_rst", 256'(busy), 256'(0));
        start_job(0, 0, 1, 2);
        wait_done("t6_recover_done", 100);

        chk("end_addr_q_empty", 256'(addr_q.size()), 256'(0));
        chk("end_beat_q_empty", 256'(beat_q.size()), 256'(0));
        chk("end_tile_q_empty", 256'(tile_q.size()), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
